// File: rtl/td4e_sequencer.sv
// td4e_sequencer: fetch/execute controller for the TD4E core (PC, carry, imem/dmem handshakes, commit).
// Define STEP_EN for single-step mode: a step input and a PAUSE state entered after every WB.
module td4e_sequencer #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef STEP_EN
    input  logic              step,
`endif
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    output logic [3:0]        instr,
    output logic [DATA_W-1:0] imm,
    output logic              c_flag,
    input  logic              alu_carry,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              commit,
    output logic [PC_W-1:0]   pc
);
    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, PAUSE} state_t;

    state_t state, state_nx;
    logic   jump, taken;

    assign jump  = instr[3:1] == 3'b111;
    assign taken = instr == 4'b1111 || (instr == 4'b1110 && !c_flag);

`ifdef STEP_EN
    localparam state_t RST_STATE = PAUSE;
    localparam state_t WB_NEXT   = PAUSE;
    logic step_r, step_q, step_pend, step_rise, go;
    assign step_rise = step_r && !step_q;
    assign go        = step_rise || step_pend;
    // a step edge arriving mid-instruction is held until the next PAUSE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r    <= 1'b0;
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_r    <= step;
            step_q    <= step_r;
            step_pend <= state != PAUSE && (step_pend || step_rise);
        end
    end
`else
    localparam state_t RST_STATE = FETCH;
    localparam state_t WB_NEXT   = FETCH;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            c_flag <= 1'b0;
            instr  <= '0;
            imm    <= '0;
        end else begin
            if (state == FETCH && imem_ack) begin
                instr <= imem_data[7:4];
                imm   <= DATA_W'(imem_data[3:0]);
            end
            if (state == WB) begin
                pc     <= taken ? PC_W'(imm) : pc + PC_W'(1);
                c_flag <= !jump && alu_carry;
            end
        end
    end

    // requests are gated by rst_n so they drop the instant reset asserts
    always_comb begin
        state_nx = state;
        imem_req = rst_n && state == FETCH;
        dmem_req = rst_n && state == MEM;
        dmem_we  = rst_n && state == MEM && instr == 4'b1101;
        commit   = rst_n && state == WB;
        case (state)
            FETCH:   state_nx = imem_ack ? EXEC : FETCH;
            EXEC:    state_nx = instr[3:1] == 3'b110 ? MEM : WB;
            MEM:     state_nx = dmem_ack ? WB : MEM;
            WB:      state_nx = WB_NEXT;
`ifdef STEP_EN
            PAUSE:   state_nx = go ? FETCH : PAUSE;
`endif
            default: state_nx = RST_STATE;
        endcase
    end

    assign imem_addr = pc;
endmodule

// File: tb/tb_td4e_sequencer.sv
// tb_td4e_sequencer: scoreboard bench for td4e_sequencer; each fetch queues the expected
// commit-time opcode/immediate and post-WB pc/carry, popped and compared around each commit.
module tb_td4e_sequencer;
    logic       clk = 0, rst_n = 0;
    logic       imem_ack = 0, alu_carry = 0, dmem_ack = 0;
    logic [7:0] imem_data = 0;
    logic [3:0] imem_addr, instr, imm, pc;
    logic       imem_req, c_flag, dmem_req, dmem_we, commit;
`ifdef STEP_EN
    logic       step = 0;
`endif

    typedef struct packed {logic [3:0] op, im, pc; logic c;} exp_t;
    exp_t       sb[$];
    exp_t       e;
    int         n_vec = 0, n_err = 0;
    logic [3:0] m_pc = 0;
    logic       m_c = 0, prev_commit = 0;

    td4e_sequencer dut (
        .clk(clk), .rst_n(rst_n),
`ifdef STEP_EN
        .step(step),
`endif
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .imm(imm), .c_flag(c_flag), .alu_carry(alu_carry),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .commit(commit), .pc(pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_instr(input logic [7:0] w, input logic cy);
        logic [3:0] op, npc;
        logic       tk, nc;
        op  = w[7:4];
        tk  = op == 4'hF || (op == 4'hE && !m_c);
        npc = tk ? w[3:0] : m_pc + 4'd1;
        nc  = (op == 4'hE || op == 4'hF) ? 1'b0 : cy;
        sb.push_back('{op, w[3:0], npc, nc});
        m_pc = npc;
        m_c  = nc;
    endtask

    task automatic wait_fetch();
`ifdef STEP_EN
        step = 1;
        for (int k = 0; k < 6 && !imem_req; k++) @(negedge clk);
        step = 0;
`endif
    endtask

    // runs one instruction from a FETCH negedge to the following FETCH/PAUSE negedge
    task automatic exec(input logic [7:0] w, input logic cy, input int wt);
        int   n, mem_n, we_n, req_n;
        bit   done;
        logic mem;
        n = 1; mem_n = 0; we_n = 0; req_n = 0; done = 0;
        mem = w[7:5] == 3'b110;
        wait_fetch();
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        expect_instr(w, cy);
        imem_data = w; imem_ack = 1; alu_carry = cy;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            n++;
            imem_ack = 0; dmem_ack = 0;
            req_n += imem_req;
            if (commit) done = 1;
            else if (dmem_req) begin
                mem_n++;
                we_n += dmem_we;
                if (mem_n > wt) dmem_ack = 1;
            end
        end
        check("commit_seen", done, 1);
        check("cycles", n, mem ? 4 + wt : 3);
        check("imem_req_after_fetch", req_n, 0);
        check("dmem_req_cycles", mem_n, mem ? wt + 1 : 0);
        check("dmem_we_cycles", we_n, w[7:4] == 4'hD ? wt + 1 : 0);
        @(negedge clk);
        check("commit_one_cycle", commit, 0);
    endtask

    always @(negedge clk) begin
        if (commit) begin
            check("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                check("instr", instr, sb[0].op);
                check("imm", imm, sb[0].im);
            end
        end
        if (prev_commit && sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("c_flag", c_flag, e.c);
        end
        prev_commit = commit;
    end

    initial begin
        #7;
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_commit", commit, 0);
        check("rst_pc", pc, 0);
        check("rst_c_flag", c_flag, 0);
        check("rst_instr", instr, 0);
        check("rst_imm", imm, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        exec(8'h35, 0, 0);
        exec(8'h03, 1, 0);
        exec(8'hE7, 0, 0);
        exec(8'hE7, 0, 0);
        exec(8'hFF, 0, 0);
        exec(8'hF0, 0, 0);
        exec(8'hFF, 0, 0);
        exec(8'h31, 1, 0);
        exec(8'hD4, 0, 3);
        exec(8'hC2, 1, 0);
        exec(8'hC2, 0, 2);
        exec(8'hD9, 1, 1);
        repeat (24) exec(8'($urandom), 1'($urandom), $urandom_range(0, 2));

        // reset in the middle of a store
        wait_fetch();
        imem_data = 8'hD9; imem_ack = 1;
        @(negedge clk); imem_ack = 0;
        @(negedge clk);
        check("mem_req_before_rst", dmem_req, 1);
        #2 rst_n = 0;
        #1;
        check("rst_mid_dmem_req", dmem_req, 0);
        check("rst_mid_dmem_we", dmem_we, 0);
        check("rst_mid_commit", commit, 0);
        check("rst_mid_pc", pc, 0);
        check("rst_mid_imem_req", imem_req, 0);
        m_pc = 0; m_c = 0; sb.delete();
        @(negedge clk); rst_n = 1;
        @(negedge clk);
`ifndef STEP_EN
        check("resume_req", imem_req, 1);
        check("resume_addr", imem_addr, 0);
`endif
        exec(8'h35, 0, 0);
        exec(8'h12, 0, 0);
        exec(8'h23, 1, 0);
`ifdef STEP_EN
        check("step_pc_after_three", pc, 3);
        begin : hold
            int cnt;
            cnt = 0;
            expect_instr(8'h35, 0);
            imem_data = 8'h35; imem_ack = 1; alu_carry = 0; step = 1;
            repeat (30) begin
                @(negedge clk);
                cnt += commit;
                if (commit) imem_ack = 0;
            end
            step = 0; imem_ack = 0;
            check("step_hold_commits", cnt, 1);
            check("step_hold_pc", pc, 4);
        end
`endif
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
